keygen_sequencer: RTL and testbench



---
 rtl/kyber_pkg.sv | 23 ++
 rtl/keygen_sequencer_coeff_sampler.sv | 25 ++
 rtl/keygen_sequencer.sv | 140 ++++++++++++++
 tb/tb_keygen_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Baby Kyber (q=17, n=4, k=2) constants, types and helpers.
// Provides coefficient modulus/sizes, polynomial container types, the key
// generation FSM state enum and a two-step modular reduction helper.
package kyber_pkg;
  localparam int Q = 17;
  localparam int N = 4;
  localparam int K = 2;
  localparam int COEFF_W = 32;
  localparam int CW = $clog2(Q);
  localparam int WORDS = (2 * K + K * K) * N;
  localparam int A_OFS = K * N;
  localparam int E_OFS = A_OFS + K * K * N;
  typedef logic [N-1:0][COEFF_W-1:0] poly_t;
  typedef poly_t [K-1:0] polyvec_t;
  typedef enum logic [1:0] {IDLE, LOAD, MUL, OUT} kg_state_e;
  // Inputs are below 3Q, so two conditional subtracts land in [0,Q).
  function automatic logic [CW-1:0] mod_q(input logic [CW:0] x);
    logic [CW:0] y;
    y = x >= (CW+1)'(Q) ? x - (CW+1)'(Q) : x;
    y = y >= (CW+1)'(Q) ? y - (CW+1)'(Q) : y;
    return CW'(y);
  endfunction
endpackage

// File: rtl/keygen_sequencer_coeff_sampler.sv
// coeff_sampler: maps one random word to a coefficient in [0,Q).
// Ports: word (random word), is_noise (coefficient belongs to s or e),
// coeff (sampled coefficient). With KEYGEN_CBD_NOISE_EN defined, noise
// coefficients use a centered binomial (eta=2) on word[3:0]; otherwise every
// coefficient is word mod Q.
module coeff_sampler
  import kyber_pkg::*;
(
  input  logic [COEFF_W-1:0] word,
  input  logic               is_noise,
  output logic [CW-1:0]      coeff
);
  logic [CW-1:0] uni, cbd;
  assign uni = CW'(word % COEFF_W'(Q));
`ifdef KEYGEN_CBD_NOISE_EN
  logic [2:0] pos, neg;
  assign pos = {2'b0, word[0]} + {2'b0, word[1]};
  assign neg = {2'b0, word[2]} + {2'b0, word[3]};
  // Negative draws wrap to Q-d so -1 -> 16, -2 -> 15.
  assign cbd = pos >= neg ? CW'(pos - neg) : CW'(Q) - CW'(neg - pos);
`else
  assign cbd = uni;
`endif
  assign coeff = is_noise ? cbd : uni;
endmodule

// File: rtl/keygen_sequencer.sv
// keygen_sequencer: Baby Kyber key generation t = A*s + e using one shared
// external polynomial multiplier.
// Ports: clk/rst_n (async active-low reset), start/abort control, busy/done
// status; rnd_valid/rnd_ready/rnd_data random word stream (32 words: s, A, e);
// mul_req/mul_ack/mul_a/mul_b/mul_res multiplier handshake; t_valid/t_ready
// output handshake with t_data (public t) and sk_data (secret s).
// Optional feature macro: KEYGEN_CBD_NOISE_EN (CBD noise sampling for s and e).
module keygen_sequencer
  import kyber_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  input  logic                     rnd_valid,
  input  logic [COEFF_W-1:0]       rnd_data,
  output logic                     rnd_ready,
  output logic                     mul_req,
  output logic [N*COEFF_W-1:0]     mul_a,
  output logic [N*COEFF_W-1:0]     mul_b,
  input  logic                     mul_ack,
  input  logic [N*COEFF_W-1:0]     mul_res,
  output logic                     t_valid,
  input  logic                     t_ready,
  output logic [K*N*COEFF_W-1:0]   t_data,
  output logic [K*N*COEFF_W-1:0]   sk_data
);
  kg_state_e     state;
  logic [4:0]    cnt;
  logic [1:0]    p;
  logic [CW-1:0] mem [WORDS];
  logic [CW-1:0] acc [K][N];
  logic [CW-1:0] t_q [K][N];
  logic [CW-1:0] red [N];
  logic [CW-1:0] nxt [N];
  logic [CW-1:0] coeff;
  logic          noise;
  logic [4:0]    a_base, s_base, e_base;
  poly_t         a_p, b_p, r_p;
  polyvec_t      s_pv, t_pv;
  // Word memory layout follows load order: s at 0, A at A_OFS, e at E_OFS.
  assign noise = cnt < 5'(A_OFS) || cnt >= 5'(E_OFS);
  coeff_sampler u_sampler (.word(rnd_data), .is_noise(noise), .coeff(coeff));
  // Product p selects (i,j) = (p[1], p[0]); A[i][j] sits at A_OFS + 4p.
  assign a_base = 5'(A_OFS) + {1'b0, p, 2'b00};
  assign s_base = {2'b00, p[0], 2'b00};
  assign e_base = 5'(E_OFS) + {2'b00, p[1], 2'b00};
  assign r_p = mul_res;
  always_comb begin
    for (int k = 0; k < N; k++) begin
      a_p[k] = COEFF_W'(mem[a_base + 5'(k)]);
      b_p[k] = COEFF_W'(mem[s_base + 5'(k)]);
      red[k] = CW'(r_p[k] % COEFF_W'(Q));
      nxt[k] = mod_q((CW+1)'(acc[p[1]][k]) + (CW+1)'(red[k]) + (CW+1)'(mem[e_base + 5'(k)]));
    end
    for (int i = 0; i < K; i++)
      for (int k = 0; k < N; k++) begin
        s_pv[i][k] = COEFF_W'(mem[5'(i * N + k)]);
        t_pv[i][k] = COEFF_W'(t_q[i][k]);
      end
  end
  assign mul_a = a_p;
  assign mul_b = b_p;
  assign sk_data = s_pv;
  assign t_data = t_pv;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      p <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rnd_ready <= 1'b0;
      mul_req <= 1'b0;
      t_valid <= 1'b0;
      for (int n = 0; n < WORDS; n++) mem[n] <= '0;
      for (int i = 0; i < K; i++)
        for (int k = 0; k < N; k++) begin
          acc[i][k] <= '0;
          t_q[i][k] <= '0;
        end
    end else if (abort) begin
      // Abort outranks any same-cycle mul_ack or t_ready, so nothing commits.
      state <= IDLE;
      cnt <= '0;
      p <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rnd_ready <= 1'b0;
      mul_req <= 1'b0;
      t_valid <= 1'b0;
      for (int i = 0; i < K; i++)
        for (int k = 0; k < N; k++) acc[i][k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          p <= '0;
          for (int i = 0; i < K; i++)
            for (int k = 0; k < N; k++) acc[i][k] <= '0;
          if (start) begin
            state <= LOAD;
            busy <= 1'b1;
            rnd_ready <= 1'b1;
          end
        end
        LOAD: if (rnd_valid) begin
          mem[cnt] <= coeff;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(WORDS - 1)) begin
            state <= MUL;
            rnd_ready <= 1'b0;
            mul_req <= 1'b1;
          end
        end
        MUL: if (mul_ack) begin
          // j=0 seeds the row accumulator; j=1 finishes t[i] including e[i].
          for (int k = 0; k < N; k++)
            if (p[0]) t_q[p[1]][k] <= nxt[k];
            else acc[p[1]][k] <= red[k];
          p <= p + 2'd1;
          if (p == 2'd3) begin
            state <= OUT;
            mul_req <= 1'b0;
            t_valid <= 1'b1;
          end
        end
        OUT: if (t_ready) begin
          state <= IDLE;
          t_valid <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_keygen_sequencer.sv
// tb_keygen_sequencer: self-checking bench for keygen_sequencer with a
// negacyclic multiplier model, fixed vector table, hand sequences and
// randomized runs checked against an arithmetic reference model.
module tb_keygen_sequencer;
  import kyber_pkg::*;
  localparam int VW = K * N * COEFF_W;
  localparam int PW = N * COEFF_W;
`ifdef KEYGEN_CBD_NOISE_EN
  localparam bit CBD = 1'b1;
`else
  localparam bit CBD = 1'b0;
`endif
  logic clk, rst_n, start, abort, busy, done, rnd_valid, rnd_ready;
  logic mul_req, mul_ack, t_valid, t_ready;
  logic [COEFF_W-1:0] rnd_data;
  logic [PW-1:0] mul_a, mul_b, mul_res;
  logic [VW-1:0] t_data, sk_data;
  keygen_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack), .mul_res(mul_res),
    .t_valid(t_valid), .t_ready(t_ready), .t_data(t_data), .sk_data(sk_data)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // External multiplier: negacyclic product mod x^4+1, then mod 17.
  int ack_delay = 0;
  int wait_cnt;
  function automatic logic [PW-1:0] negamul(input logic [PW-1:0] a, input logic [PW-1:0] b);
    int r[N];
    logic [PW-1:0] o;
    for (int k = 0; k < N; k++) r[k] = 0;
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++)
        if (x + y < N) r[x+y] += int'(a[x*COEFF_W +: COEFF_W]) * int'(b[y*COEFF_W +: COEFF_W]);
        else r[x+y-N] -= int'(a[x*COEFF_W +: COEFF_W]) * int'(b[y*COEFF_W +: COEFF_W]);
    for (int k = 0; k < N; k++) o[k*COEFF_W +: COEFF_W] = COEFF_W'(((r[k] % Q) + Q) % Q);
    return o;
  endfunction
  assign mul_res = negamul(mul_a, mul_b);
  assign mul_ack = mul_req && (wait_cnt >= ack_delay);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) wait_cnt <= 0;
    else wait_cnt <= (mul_req && !mul_ack) ? wait_cnt + 1 : 0;
  int tests = 0, fails = 0;
  task automatic check_v(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic check_i(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Reference model: sample the 32 words, then t[i] = sum_j A[i][j]*s[j] + e[i]
  // in Z_17[x]/(x^4+1) using plain integer sums.
  int unsigned words[WORDS];
  logic [VW-1:0] exp_t_vec, exp_s_vec;
  function automatic int samp(input int unsigned w, input bit noise);
    int v;
    if (noise && CBD) begin
      v = int'(w[0]) + int'(w[1]) - int'(w[2]) - int'(w[3]);
      return (v + Q) % Q;
    end
    return int'(w % Q);
  endfunction
  task automatic compute_ref();
    int c[WORDS];
    int s;
    for (int n = 0; n < WORDS; n++) c[n] = samp(words[n], n < 8 || n >= 24);
    for (int i = 0; i < K; i++)
      for (int k = 0; k < N; k++) begin
        s = c[24 + i*N + k];
        for (int j = 0; j < K; j++)
          for (int x = 0; x < N; x++)
            for (int y = 0; y < N; y++)
              if ((x + y) % N == k)
                s += (x + y < N ? 1 : -1) * c[8 + (i*K + j)*N + x] * c[j*N + y];
        exp_t_vec[(i*N + k)*COEFF_W +: COEFF_W] = COEFF_W'(((s % Q) + Q) % Q);
        exp_s_vec[(i*N + k)*COEFF_W +: COEFF_W] = COEFF_W'(c[i*N + k]);
      end
  endtask
  task automatic fill(input int unsigned sv, input int unsigned av, input int unsigned ev);
    for (int n = 0; n < WORDS; n++) words[n] = n < 8 ? sv : (n < 24 ? av : ev);
  endtask
  // Per-run observations.
  int tv_cyc, dn_cyc, dones, extra_done;
  bit stable, coincide, busy_at_done, aborted, reset_hit, finished, tv_seen;
  logic [VW-1:0] t_first, s_first;
  // Entered and left at 1 time unit after a rising edge; cycle numbering makes
  // the edge that samples start the end of cycle 0.
  task automatic run_kg(input bit gap, input int ackd, input int trd, input int abort_p,
                        input int rst_beat, input bit pulse);
    int k, cyc, xf;
    bit fire;
    ack_delay = ackd;
    k = 0; xf = 0; tv_cyc = -1; dn_cyc = -1; dones = 0; stable = 1; coincide = 0;
    busy_at_done = 1; aborted = 0; reset_hit = 0; finished = 0;
    t_first = '0; s_first = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!finished && cyc < 2000) begin
      if (t_valid) begin
        if (tv_cyc < 0) begin
          tv_cyc = cyc;
          t_first = t_data;
          s_first = sk_data;
        end else if (t_data !== t_first || sk_data !== s_first) stable = 0;
      end
      if (done) begin
        dones++;
        dn_cyc = cyc;
        coincide = t_valid;
        busy_at_done = busy;
        finished = 1;
      end else if (rst_beat >= 0 && k == rst_beat) begin
        rnd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        reset_hit = 1;
        finished = 1;
      end else begin
        rnd_valid = (k < WORDS) && (!gap || cyc[0]);
        rnd_data = k < WORDS ? words[k] : 0;
        t_ready = tv_cyc >= 0 && (cyc - tv_cyc) >= trd;
        start = pulse && (cyc == 5 || (tv_cyc >= 0 && cyc == tv_cyc + 1));
        if (mul_req && mul_ack) begin
          if (xf == abort_p) begin
            abort = 1'b1;
            aborted = 1;
            finished = 1;
          end
          xf++;
        end
        fire = rnd_valid && rnd_ready;
        @(posedge clk); #1;
        if (fire) k++;
        cyc++;
      end
    end
    check_i("run_finished", int'(finished), 1);
    start = 1'b0;
    rnd_valid = 1'b0;
  endtask
  task automatic watch(input int n);
    extra_done = 0;
    tv_seen = 0;
    t_ready = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
      if (t_valid) tv_seen = 1;
    end
  endtask
  task automatic post_checks(input string tag, input int exp_tv, input int exp_dn);
    check_v({tag, "_t_data"}, t_first, exp_t_vec);
    check_v({tag, "_sk_data"}, s_first, exp_s_vec);
    check_i({tag, "_done_count"}, dones, 1);
    check_i({tag, "_busy_at_done"}, int'(busy_at_done), 0);
    check_i({tag, "_done_with_tvalid"}, int'(coincide), 0);
    check_i({tag, "_t_stable"}, int'(stable), 1);
    if (exp_tv != 0) check_i({tag, "_tvalid_cycle"}, tv_cyc, exp_tv);
    if (exp_dn != 0) check_i({tag, "_done_cycle"}, dn_cyc, exp_dn);
    watch(5);
    check_i({tag, "_extra_done"}, extra_done, 0);
  endtask
  typedef struct packed {
    logic [31:0] sv, av, ev;
    logic gap;
    logic [7:0] ackd, trd;
    logic [3:0][7:0] exp_t;
    logic [7:0] exp_s, exp_tv, exp_dn;
  } vec_t;
  vec_t vecs[4];
  task automatic load_expect(input vec_t v);
    for (int i = 0; i < K; i++)
      for (int k = 0; k < N; k++) begin
        exp_t_vec[(i*N + k)*COEFF_W +: COEFF_W] = COEFF_W'(v.exp_t[k]);
        exp_s_vec[(i*N + k)*COEFF_W +: COEFF_W] = COEFF_W'(v.exp_s);
      end
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rnd_valid = 1'b0; rnd_data = '0; t_ready = 1'b0;
    vecs[0] = '{sv: 35, av: 35, ev: 35, gap: 0, ackd: 0, trd: 0,
                exp_t: CBD ? {8'd1, 8'd10, 8'd2, 8'd11} : {8'd9, 8'd5, 8'd1, 8'd14},
                exp_s: CBD ? 8'd2 : 8'd1, exp_tv: 37, exp_dn: 38};
    vecs[1] = '{sv: 35, av: 35, ev: 35, gap: 1, ackd: 3, trd: 5,
                exp_t: CBD ? {8'd1, 8'd10, 8'd2, 8'd11} : {8'd9, 8'd5, 8'd1, 8'd14},
                exp_s: CBD ? 8'd2 : 8'd1, exp_tv: 0, exp_dn: 0};
    vecs[2] = '{sv: 3, av: 1, ev: 3, gap: 0, ackd: 0, trd: 0,
                exp_t: CBD ? {8'd1, 8'd10, 8'd2, 8'd11} : {8'd10, 8'd15, 8'd3, 8'd8},
                exp_s: CBD ? 8'd2 : 8'd3, exp_tv: 37, exp_dn: 38};
    vecs[3] = '{sv: 20, av: 18, ev: 17, gap: 1, ackd: 1, trd: 2,
                exp_t: CBD ? {8'd10, 8'd14, 8'd1, 8'd5} : {8'd7, 8'd12, 8'd0, 8'd5},
                exp_s: CBD ? 8'd16 : 8'd3, exp_tv: 0, exp_dn: 0};
    repeat (2) @(posedge clk);
    #1;
    check_i("reset_ctrl", int'({busy, done, rnd_ready, mul_req, t_valid}), 0);
    check_v("reset_t_data", t_data, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int v = 0; v < 4; v++) begin
      fill(vecs[v].sv, vecs[v].av, vecs[v].ev);
      load_expect(vecs[v]);
      run_kg(vecs[v].gap, int'(vecs[v].ackd), int'(vecs[v].trd), -1, -1, 0);
      post_checks($sformatf("vec%0d", v), int'(vecs[v].exp_tv), int'(vecs[v].exp_dn));
    end
    // Abort while the third product (p=2) is being transferred.
    fill(35, 35, 35);
    run_kg(0, 0, 0, 2, -1, 0);
    check_i("abort_reached", int'(aborted), 1);
    check_i("abort_busy", int'(busy), 0);
    check_i("abort_mul_req", int'(mul_req), 0);
    abort = 1'b0;
    watch(40);
    check_i("abort_no_tvalid", int'(tv_seen), 0);
    check_i("abort_no_done", extra_done, 0);
    load_expect(vecs[0]);
    run_kg(0, 0, 0, -1, -1, 0);
    post_checks("after_abort", 37, 38);
    // Asynchronous reset after 10 load beats.
    run_kg(0, 0, 0, -1, 10, 0);
    check_i("rst_reached", int'(reset_hit), 1);
    check_i("rst_ctrl", int'({busy, done, rnd_ready, mul_req, t_valid}), 0);
    check_v("rst_t_data", t_data, '0);
    check_v("rst_sk_data", sk_data, '0);
    check_v("rst_mul_ab", {mul_a, mul_b}, '0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_kg(0, 0, 0, -1, -1, 0);
    post_checks("after_reset", 37, 38);
    // start pulses during LOAD and OUT; t_ready held low for 5 cycles.
    run_kg(0, 0, 5, -1, -1, 1);
    post_checks("start_pulse", 37, 43);
    watch(40);
    check_i("start_pulse_no_rerun", extra_done, 0);
    check_i("start_pulse_idle", int'(busy), 0);
    // Randomized words and stalls against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < WORDS; n++) words[n] = $urandom;
      compute_ref();
      run_kg(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4), -1, -1, 0);
      post_checks($sformatf("rand%0d", r), 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
